deser_word_aligner: RTL and testbench



---
 rtl/deser_word_aligner.sv | 168 ++++++++++++++++
 tb/tb_deser_word_aligner.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/deser_word_aligner.sv
// rtl/deser_word_aligner.sv - sync-word hunter and WIDTH-bit framer for the recovered serial stream
// Optional macro DESER_POLARITY_DETECT_EN: lock on an inverted sync word and un-invert the payload.
module deser_word_aligner #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] SYNC_PATTERN = WIDTH'(8'hBC),
  parameter int               FRAME_WORDS  = 4,
  parameter int               LOSS_THRESH  = 3
) (
  input  logic             ref_clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic             locked,
  output logic             overflow
`ifdef DESER_POLARITY_DETECT_EN
  ,
  output logic             rx_inverted
`endif
);

  localparam int FW = $clog2(WIDTH + 1);
  localparam int BW = $clog2(WIDTH);
  localparam int WW = $clog2(FRAME_WORDS + 1);
  localparam int MW = $clog2(LOSS_THRESH + 1);

  localparam logic [FW-1:0] FILL_MAX  = FW'(WIDTH);
  localparam logic [FW-1:0] FILL_LOCK = FW'(WIDTH - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
  localparam logic [WW-1:0] SYNC_SLOT = WW'(FRAME_WORDS);
  localparam logic [WW-1:0] LAST_WORD = WW'(FRAME_WORDS - 1);
  localparam logic [MW-1:0] MISS_MAX  = MW'(LOSS_THRESH);

  typedef enum logic [0:0] {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sr, sr_n, sr_next;
  logic [FW-1:0]    fill, fill_n;
  logic [BW-1:0]    bit_cnt, bit_cnt_n;
  logic [WW-1:0]    word_cnt, word_cnt_n;
  logic [MW-1:0]    miss_cnt, miss_cnt_n;
  logic             new_word;
  logic [WIDTH-1:0] new_data;
  logic             new_last;
  logic [WIDTH-1:0] sync_expect;

`ifdef DESER_POLARITY_DETECT_EN
  logic pol, pol_n;
  assign rx_inverted = pol;
  assign sync_expect = pol ? ~SYNC_PATTERN : SYNC_PATTERN;
`else
  assign sync_expect = SYNC_PATTERN;
`endif

  always_comb begin
    sr_next    = {sr[WIDTH-2:0], bit_in};
    state_n    = state;
    sr_n       = sr;
    fill_n     = fill;
    bit_cnt_n  = bit_cnt;
    word_cnt_n = word_cnt;
    miss_cnt_n = miss_cnt;
    new_word   = 1'b0;
    new_last   = (word_cnt == LAST_WORD);
`ifdef DESER_POLARITY_DETECT_EN
    pol_n      = pol;
    new_data   = pol ? ~sr_next : sr_next;
`else
    new_data   = sr_next;
`endif
    if (bit_valid) begin
      sr_n = sr_next;
      case (state)
        ST_HUNT: begin
          fill_n = (fill == FILL_MAX) ? FILL_MAX : fill + 1'b1;
          if (fill >= FILL_LOCK && sr_next == SYNC_PATTERN) begin
            state_n    = ST_LOCKED;
            bit_cnt_n  = '0;
            word_cnt_n = '0;
            miss_cnt_n = '0;
`ifdef DESER_POLARITY_DETECT_EN
            pol_n      = 1'b0;
          end else if (fill >= FILL_LOCK && sr_next == ~SYNC_PATTERN) begin
            state_n    = ST_LOCKED;
            bit_cnt_n  = '0;
            word_cnt_n = '0;
            miss_cnt_n = '0;
            pol_n      = 1'b1;
`endif
          end
        end
        default: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt_n = '0;
            if (word_cnt != SYNC_SLOT) begin
              new_word   = 1'b1;
              word_cnt_n = word_cnt + 1'b1;
            end else begin
              word_cnt_n = '0;
              if (sr_next == sync_expect) begin
                miss_cnt_n = '0;
              end else if (miss_cnt + 1'b1 == MISS_MAX) begin
                // Window already holds WIDTH valid bits, so hunting resumes on the very next bit.
                state_n    = ST_HUNT;
                fill_n     = FILL_MAX;
                miss_cnt_n = '0;
              end else begin
                miss_cnt_n = miss_cnt + 1'b1;
              end
            end
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge ref_clk) begin
    if (!rst_n) begin
      state         <= ST_HUNT;
      sr            <= '0;
      fill          <= '0;
      bit_cnt       <= '0;
      word_cnt      <= '0;
      miss_cnt      <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      locked        <= 1'b0;
      overflow      <= 1'b0;
`ifdef DESER_POLARITY_DETECT_EN
      pol           <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      sr       <= sr_n;
      fill     <= fill_n;
      bit_cnt  <= bit_cnt_n;
      word_cnt <= word_cnt_n;
      miss_cnt <= miss_cnt_n;
      locked   <= (state_n == ST_LOCKED);
      overflow <= 1'b0;
`ifdef DESER_POLARITY_DETECT_EN
      pol      <= pol_n;
`endif
      // A blocked holding register keeps its word; the newcomer is the one lost.
      if (new_word) begin
        if (m_axis_tvalid && !m_axis_tready) begin
          overflow <= 1'b1;
        end else begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= new_data;
          m_axis_tlast  <= new_last;
        end
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_deser_word_aligner.sv
// tb/tb_deser_word_aligner.sv - table, directed and random checks of deser_word_aligner against a bit-position model
module tb_deser_word_aligner;
  localparam int         W     = 8;
  localparam logic [7:0] SYNC  = 8'hBC;
  localparam logic [7:0] NSYNC = ~SYNC;
  localparam int         F     = 4;
  localparam int         L     = 3;

  logic       ref_clk = 1'b0;
  logic       rst_n = 1'b0, bit_in = 1'b0, bit_valid = 1'b0, m_axis_tready = 1'b1;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid, m_axis_tlast, locked, overflow;
`ifdef DESER_POLARITY_DETECT_EN
  logic       rx_inverted;
`endif

  always #5 ref_clk = ~ref_clk;

  deser_word_aligner #(.WIDTH(W), .SYNC_PATTERN(SYNC), .FRAME_WORDS(F), .LOSS_THRESH(L)) dut (
    .ref_clk(ref_clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .locked(locked), .overflow(overflow)
`ifdef DESER_POLARITY_DETECT_EN
    , .rx_inverted(rx_inverted)
`endif
  );

  int checks = 0, errors = 0;

  // Reference: frame position is derived from the count of valid bits since lock.
  int m_hist, m_nbits, m_pos, m_miss, hd;
  bit m_lock, m_pol, hv, hl, m_ovf;
  logic [7:0] got[$];
  int ovf_seen;
  int rdy_sel;  // 0 always ready, 1 random, 2 never ready
  int gap_mode; // 0 none, 1 alternate, 2 random

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model(input bit rstn, input bit bv, input bit b, input bit rdy);
    bit nw = 1'b0;
    bit nl = 1'b0;
    int nd = 0;
    int slot;
    int exp_sync;
    if (!rstn) begin
      m_hist = 0; m_nbits = 0; m_pos = 0; m_miss = 0; hd = 0;
      m_lock = 0; m_pol = 0; hv = 0; hl = 0; m_ovf = 0;
      return;
    end
    m_ovf = 0;
    if (bv) begin
      m_hist = ((m_hist << 1) | int'(b)) & 32'hFF;
      m_nbits++;
      if (!m_lock) begin
        if (m_nbits >= W && m_hist == int'(SYNC)) begin
          m_lock = 1; m_pol = 0; m_pos = 0; m_miss = 0;
        end
`ifdef DESER_POLARITY_DETECT_EN
        else if (m_nbits >= W && m_hist == int'(NSYNC)) begin
          m_lock = 1; m_pol = 1; m_pos = 0; m_miss = 0;
        end
`endif
      end else begin
        m_pos++;
        if (m_pos % W == 0) begin
          slot = (m_pos / W - 1) % (F + 1);
          if (slot < F) begin
            nw = 1;
            nd = m_pol ? (m_hist ^ 32'hFF) : m_hist;
            nl = (slot == F - 1);
          end else begin
            exp_sync = m_pol ? int'(NSYNC) : int'(SYNC);
            if (m_hist == exp_sync) m_miss = 0;
            else begin
              m_miss++;
              if (m_miss == L) begin
                m_lock = 0;
                m_miss = 0;
              end
            end
          end
        end
      end
    end
    if (nw) begin
      if (hv && !rdy) m_ovf = 1;
      else begin
        hv = 1; hd = nd; hl = nl;
      end
    end else if (hv && rdy) hv = 0;
  endfunction

  task automatic step(input bit rstn, input bit bv, input bit b);
    bit rdy;
    rdy = (rdy_sel == 0) ? 1'b1 : (rdy_sel == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    rst_n = rstn; bit_valid = bv; bit_in = b; m_axis_tready = rdy;
    if (rstn && m_axis_tvalid === 1'b1 && rdy) got.push_back(m_axis_tdata);
    @(posedge ref_clk);
    model(rstn, bv, b, rdy);
    #1;
    chk("tvalid", int'(m_axis_tvalid), int'(hv));
    chk("locked", int'(locked), int'(m_lock));
    chk("overflow", int'(overflow), int'(m_ovf));
    if (hv) begin
      chk("tdata", int'(m_axis_tdata), hd);
      chk("tlast", int'(m_axis_tlast), int'(hl));
    end
`ifdef DESER_POLARITY_DETECT_EN
    chk("rx_inverted", int'(rx_inverted), int'(m_pol));
`endif
    if (overflow === 1'b1) ovf_seen++;
  endtask

  task automatic do_reset();
    step(0, 0, 0);
    chk("rst_tdata", int'(m_axis_tdata), 0);
    chk("rst_tlast", int'(m_axis_tlast), 0);
    got.delete();
    ovf_seen = 0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) begin
      if (gap_mode == 2) while ($urandom_range(0, 2) == 0) step(1, 0, 1'($urandom_range(0, 1)));
      step(1, 1, w[i]);
      if (gap_mode == 1) step(1, 0, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic send_frame(input logic [7:0] s, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
    send_word(s); send_word(a); send_word(b); send_word(c); send_word(d);
  endtask

  task automatic lead_bits();
    for (int i = 0; i < 3; i++) step(1, 1, 1'($urandom_range(0, 1)));
  endtask

  task automatic chk_got(input string name, input logic [7:0] exp[$]);
    chk({name, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) chk(name, int'(got[i]), int'(exp[i]));
  endtask

  typedef struct {
    logic [7:0] word;
    bit         exp_valid;
    logic [7:0] exp_data;
    bit         exp_last;
    bit         exp_locked;
  } vec_t;

  vec_t tbl[10];
  logic [7:0] main_words[$] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

  initial begin
    tbl[0] = '{8'hBC, 0, 8'h00, 0, 1};
    tbl[1] = '{8'h11, 1, 8'h11, 0, 1};
    tbl[2] = '{8'h22, 1, 8'h22, 0, 1};
    tbl[3] = '{8'h33, 1, 8'h33, 0, 1};
    tbl[4] = '{8'h44, 1, 8'h44, 1, 1};
    tbl[5] = '{8'hBC, 0, 8'h00, 0, 1};
    tbl[6] = '{8'h55, 1, 8'h55, 0, 1};
    tbl[7] = '{8'h66, 1, 8'h66, 0, 1};
    tbl[8] = '{8'h77, 1, 8'h77, 0, 1};
    tbl[9] = '{8'h88, 1, 8'h88, 1, 1};
    rdy_sel = 0; gap_mode = 0;

    // Lock and emit: explicit expectations right after each word's last bit.
    do_reset();
    chk("rst_tvalid", int'(m_axis_tvalid), 0);
    chk("rst_locked", int'(locked), 0);
    lead_bits();
    for (int i = 0; i < 10; i++) begin
      send_word(tbl[i].word);
      chk("tbl_tvalid", int'(m_axis_tvalid), int'(tbl[i].exp_valid));
      chk("tbl_locked", int'(locked), int'(tbl[i].exp_locked));
      if (tbl[i].exp_valid) begin
        chk("tbl_tdata", int'(m_axis_tdata), int'(tbl[i].exp_data));
        chk("tbl_tlast", int'(m_axis_tlast), int'(tbl[i].exp_last));
      end
    end
    step(1, 0, 0);
    chk_got("lock_words", main_words);

    // Gapped input gives the same word sequence.
    gap_mode = 1;
    do_reset(); lead_bits();
    send_frame(SYNC, 8'h11, 8'h22, 8'h33, 8'h44);
    send_frame(SYNC, 8'h55, 8'h66, 8'h77, 8'h88);
    step(1, 0, 0);
    chk_got("gap_words", main_words);
    gap_mode = 0;

    // Backpressure: first word held, next three dropped.
    do_reset(); lead_bits();
    send_word(SYNC);
    rdy_sel = 2;
    send_word(8'h11); send_word(8'h22); send_word(8'h33); send_word(8'h44);
    chk("bp_overflows", ovf_seen, 3);
    rdy_sel = 0;
    send_frame(SYNC, 8'h55, 8'h66, 8'h77, 8'h88);
    step(1, 0, 0);
    chk("bp_overflows_after", ovf_seen, 3);
    chk_got("bp_words", '{8'h11, 8'h55, 8'h66, 8'h77, 8'h88});

    // Loss of lock after three consecutive bad sync slots.
    do_reset(); lead_bits();
    send_frame(SYNC, 8'h11, 8'h22, 8'h33, 8'h44);
    send_frame(8'h00, 8'h11, 8'h22, 8'h33, 8'h44);
    send_frame(8'h00, 8'h11, 8'h22, 8'h33, 8'h44);
    chk("lol_before", int'(locked), 1);
    send_word(8'h00);
    chk("lol_after", int'(locked), 0);

    // Isolated misses separated by a good sync keep lock.
    do_reset(); lead_bits();
    send_frame(SYNC, 8'h11, 8'h22, 8'h33, 8'h44);
    send_frame(8'h00, 8'h11, 8'h22, 8'h33, 8'h44);
    send_frame(8'h00, 8'h11, 8'h22, 8'h33, 8'h44);
    send_frame(SYNC, 8'h11, 8'h22, 8'h33, 8'h44);
    send_frame(8'h00, 8'h11, 8'h22, 8'h33, 8'h44);
    send_frame(8'h00, 8'h11, 8'h22, 8'h33, 8'h44);
    chk("miss_reset_locked", int'(locked), 1);

    // Reset mid-frame, then relock only on a fresh sync word.
    do_reset(); lead_bits();
    send_word(SYNC); send_word(8'h11);
    for (int i = 7; i >= 3; i--) step(1, 1, main_words[1][i]);
    step(0, 1, 1);
    chk("midrst_tvalid", int'(m_axis_tvalid), 0);
    chk("midrst_locked", int'(locked), 0);
    send_word(8'h11); send_word(8'h22); send_word(8'h33); send_word(8'h44);
    chk("midrst_nolock", int'(locked), 0);
    send_word(SYNC);
    chk("midrst_relock", int'(locked), 1);

    // Inverted stream: locks only when polarity detection is built in.
    do_reset(); lead_bits();
    send_frame(NSYNC, 8'hEE, 8'hDD, 8'hCC, 8'hBB);
    send_frame(NSYNC, 8'hAA, 8'h99, 8'h88, 8'h77);
    step(1, 0, 0);
`ifdef DESER_POLARITY_DETECT_EN
    chk("inv_locked", int'(locked), 1);
    chk("inv_flag", int'(rx_inverted), 1);
    chk_got("inv_words", main_words);
`else
    chk("inv_locked", int'(locked), 0);
    chk("inv_words_count", got.size(), 0);
`endif

    // Random frames, corrupted syncs, slips, gaps and backpressure against the model.
    rdy_sel = 1; gap_mode = 2;
    do_reset(); lead_bits();
    for (int fr = 0; fr < 40; fr++) begin
      if ($urandom_range(0, 14) == 0) step(1, 1, 1'($urandom_range(0, 1)));
      send_word(($urandom_range(0, 4) == 0) ? 8'($urandom) : SYNC);
      for (int k = 0; k < F; k++) send_word(8'($urandom));
    end
    rdy_sel = 0;
    for (int i = 0; i < 4; i++) step(1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
